messbauer_camac_dataway_master: RTL

MESSBAUER_CAMAC_DATAWAY_MASTER -- requirements
Module: messbauer_camac_dataway_master

---
 rtl/messbauer_camac_dataway_master_if.sv | 40 ++++
 rtl/messbauer_camac_dataway_master.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/messbauer_camac_dataway_master_if.sv
// Command/response handshake and CAMAC dataway lines of the dataway master.
// The master modport is the controller's view; the slave modport is the host and crate side.
interface messbauer_camac_dataway_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_z;
    logic [4:0]  cmd_n;
    logic [3:0]  cmd_a;
    logic [4:0]  cmd_f;
    logic [23:0] cmd_wdata;

    logic        rsp_valid;
    logic [23:0] rsp_rdata;
    logic        rsp_q;
    logic        rsp_x;

    logic [22:0] dw_n;
    logic [3:0]  dw_a;
    logic [4:0]  dw_f;
    logic [23:0] dw_w;
    logic        dw_s1;
    logic        dw_s2;
    logic        dw_b;
    logic        dw_z;
    logic [23:0] dw_r;
    logic        dw_q;
    logic        dw_x;

    modport master (
        input  cmd_valid, cmd_z, cmd_n, cmd_a, cmd_f, cmd_wdata, dw_r, dw_q, dw_x,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_q, rsp_x,
        output dw_n, dw_a, dw_f, dw_w, dw_s1, dw_s2, dw_b, dw_z
    );

    modport slave (
        output cmd_valid, cmd_z, cmd_n, cmd_a, cmd_f, cmd_wdata, dw_r, dw_q, dw_x,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_q, rsp_x,
        input  dw_n, dw_a, dw_f, dw_w, dw_s1, dw_s2, dw_b, dw_z
    );
endinterface

// File: rtl/messbauer_camac_dataway_master.sv
// CAMAC dataway master: runs one N/A/F cycle (or a Z cycle) per accepted command.
// state   | meaning
// IDLE    | ready for a command, dataway released
// SETUP   | N/A/F/W stable before S1
// STROBE1 | S1 asserted; R/Q/X sampled on its last clock
// MID     | gap between S1 and S2
// STROBE2 | S2 asserted
// HOLD    | N/A/F/W held after S2
// DONE    | one-clock response pulse
module messbauer_camac_dataway_master #(
    parameter int unsigned SETUP_CYCLES = 20,
    parameter int unsigned S1_CYCLES    = 10,
    parameter int unsigned MID_CYCLES   = 10,
    parameter int unsigned S2_CYCLES    = 10,
    parameter int unsigned HOLD_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst,
    messbauer_camac_dataway_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE1, MID, STROBE2, HOLD, DONE} state_t;

    // Zero-length phases still take one clock.
    function automatic logic [15:0] load_val(input int unsigned c);
        return (c == 0) ? 16'd0 : 16'(c - 1);
    endfunction

    localparam logic [15:0] SETUP_LD = load_val(SETUP_CYCLES);
    localparam logic [15:0] S1_LD    = load_val(S1_CYCLES);
    localparam logic [15:0] MID_LD   = load_val(MID_CYCLES);
    localparam logic [15:0] S2_LD    = load_val(S2_CYCLES);
    localparam logic [15:0] HOLD_LD  = load_val(HOLD_CYCLES);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        accept;

    logic        z_q;
    logic [4:0]  n_q;
    logic [3:0]  a_q;
    logic [4:0]  f_q;
    logic [23:0] w_q;

    logic [23:0] r_in;
    logic        q_in, x_in;
    logic [23:0] r_smp;
    logic        q_smp, x_smp;

    logic [23:0] rsp_rdata_q;
    logic        rsp_q_q, rsp_x_q;

    logic busy, station_ok, is_write, is_read;

    assign station_ok = (n_q >= 5'd1) && (n_q <= 5'd23) && !z_q;
    assign is_write   = !z_q && (f_q >= 5'd16) && (f_q <= 5'd23);
    assign is_read    = !z_q && (f_q <= 5'd7);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt == 16'd0) begin
                    state_nxt = STROBE1;
                    cnt_nxt   = S1_LD;
                end else cnt_nxt = cnt - 16'd1;
            end
            STROBE1: begin
                if (cnt == 16'd0) begin
                    state_nxt = MID;
                    cnt_nxt   = MID_LD;
                end else cnt_nxt = cnt - 16'd1;
            end
            MID: begin
                if (cnt == 16'd0) begin
                    state_nxt = STROBE2;
                    cnt_nxt   = S2_LD;
                end else cnt_nxt = cnt - 16'd1;
            end
            STROBE2: begin
                if (cnt == 16'd0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end else cnt_nxt = cnt - 16'd1;
            end
            HOLD: begin
                if (cnt == 16'd0) begin
                    state_nxt = DONE;
                    cnt_nxt   = 16'd0;
                end else cnt_nxt = cnt - 16'd1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 16'd0;
            z_q         <= 1'b0;
            n_q         <= 5'd0;
            a_q         <= 4'd0;
            f_q         <= 5'd0;
            w_q         <= 24'd0;
            r_in        <= 24'd0;
            q_in        <= 1'b0;
            x_in        <= 1'b0;
            r_smp       <= 24'd0;
            q_smp       <= 1'b0;
            x_smp       <= 1'b0;
            rsp_rdata_q <= 24'd0;
            rsp_q_q     <= 1'b0;
            rsp_x_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            r_in  <= bus.dw_r;
            q_in  <= bus.dw_q;
            x_in  <= bus.dw_x;
            if (accept) begin
                z_q <= bus.cmd_z;
                n_q <= bus.cmd_n;
                a_q <= bus.cmd_a;
                f_q <= bus.cmd_f;
                w_q <= bus.cmd_wdata;
            end
            if (state == STROBE1 && cnt == 16'd0) begin
                r_smp <= r_in;
                q_smp <= q_in;
                x_smp <= x_in;
            end
            // Response registers change only as DONE is entered, so they stay valid until the next one.
            if (state == HOLD && cnt == 16'd0) begin
                rsp_rdata_q <= is_read ? r_smp : 24'd0;
                rsp_q_q     <= station_ok & q_smp;
                rsp_x_q     <= station_ok & x_smp;
            end
        end
    end

    assign busy = (state == SETUP) || (state == STROBE1) || (state == MID) ||
                  (state == STROBE2) || (state == HOLD);

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_q     = rsp_q_q;
    assign bus.rsp_x     = rsp_x_q;

    assign bus.dw_b  = busy;
    assign bus.dw_z  = busy & z_q;
    assign bus.dw_s1 = (state == STROBE1);
    assign bus.dw_s2 = (state == STROBE2);
    assign bus.dw_a  = (busy && !z_q) ? a_q : 4'd0;
    assign bus.dw_f  = (busy && !z_q) ? f_q : 5'd0;
    assign bus.dw_n  = (busy && station_ok) ? (23'd1 << (n_q - 5'd1)) : 23'd0;
    assign bus.dw_w  = (busy && is_write) ? w_q : 24'd0;
endmodule
